// File: rtl/regfile_onehot_wr.sv
// 16-entry register file written through a one-hot select vector, with two operand
// read ports, a debug read port, and R15 aliased to the fetch-stage PC+8 value.

module regfile_onehot_wr_entry #(
   parameter int               WIDTH     = 32,
   parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             wen,
   input  logic [WIDTH-1:0] wd,
   output logic [WIDTH-1:0] q
);
   logic [WIDTH-1:0] val_d, val_q;

   always_comb begin
      val_d = val_q;
      if (wen) val_d = wd;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) val_q <= RESET_VAL;
      else        val_q <= val_d;
   end

   assign q = val_q;
endmodule

module regfile_onehot_wr #(
   parameter int               WIDTH     = 32,
   parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             we,
   input  logic [15:0]      wsel,
   input  logic [WIDTH-1:0] wd,
   input  logic [3:0]       ra1,
   input  logic [3:0]       ra2,
   input  logic [3:0]       rdbg,
   input  logic [WIDTH-1:0] r15_in,
   output logic [WIDTH-1:0] rd1,
   output logic [WIDTH-1:0] rd2,
   output logic [WIDTH-1:0] dbg_out,
   output logic             sel_err,
   output logic [7:0]       wr_count
);
   // wsel is masked by we first, so an undriven select while idle cannot reach state.
   logic [15:0]            wsel_g;
   logic                   sel_onehot;
   logic                   commit;
   logic                   illegal;
   logic [15:0][WIDTH-1:0] regs;
   logic                   sel_err_d, sel_err_q;
   logic [7:0]             wr_count_d, wr_count_q;

   always_comb begin
      wsel_g     = we ? wsel : 16'h0000;
      sel_onehot = (wsel_g != 16'h0000) && ((wsel_g & (wsel_g - 16'd1)) == 16'h0000);
      commit     = sel_onehot && !wsel_g[15];
      illegal    = we && !sel_onehot;
   end

   for (genvar i = 0; i < 15; i++) begin : g_reg
      regfile_onehot_wr_entry #(.WIDTH(WIDTH), .RESET_VAL(RESET_VAL)) u_entry (
         .clk  (clk),
         .rst_n(rst_n),
         .wen  (commit && wsel_g[i]),
         .wd   (wd),
         .q    (regs[i])
      );
   end
   assign regs[15] = r15_in;

   assign rd1     = regs[ra1];
   assign rd2     = regs[ra2];
   assign dbg_out = regs[rdbg];

   always_comb begin
      sel_err_d  = sel_err_q | illegal;
      wr_count_d = wr_count_q;
      if (commit && wr_count_q != 8'hFF) wr_count_d = wr_count_q + 8'd1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sel_err_q  <= 1'b0;
         wr_count_q <= 8'h00;
      end else begin
         sel_err_q  <= sel_err_d;
         wr_count_q <= wr_count_d;
      end
   end

   assign sel_err  = sel_err_q;
   assign wr_count = wr_count_q;
endmodule

// File: tb/tb_regfile_onehot_wr.sv
// Bench for regfile_onehot_wr: array-based reference model, per-cycle compare on the
// falling edge, directed literal checks plus randomized traffic.

module tb_regfile_onehot_wr;
   localparam int W = 32;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          we;
   logic [15:0]   wsel;
   logic [W-1:0]  wd;
   logic [3:0]    ra1, ra2, rdbg;
   logic [W-1:0]  r15_in;
   logic [W-1:0]  rd1, rd2, dbg_out;
   logic          sel_err;
   logic [7:0]    wr_count;

   int tests = 0;
   int fails = 0;
   bit chk_on = 1'b0;

   logic [W-1:0] m [15];
   logic         m_err;
   int           m_cnt;

   regfile_onehot_wr #(.WIDTH(W), .RESET_VAL('0)) dut (
      .clk(clk), .rst_n(rst_n), .we(we), .wsel(wsel), .wd(wd),
      .ra1(ra1), .ra2(ra2), .rdbg(rdbg), .r15_in(r15_in),
      .rd1(rd1), .rd2(rd2), .dbg_out(dbg_out),
      .sel_err(sel_err), .wr_count(wr_count)
   );

   always #5 clk = ~clk;

   // Index of the single set bit, or -1 when zero or several bits are set.
   function automatic int idx_of(input logic [15:0] s);
      int n = 0;
      int k = -1;
      for (int i = 0; i < 16; i++)
         if (s[i] === 1'b1) begin n++; k = i; end
      return (n == 1) ? k : -1;
   endfunction

   function automatic logic [W-1:0] exp_rd(input logic [3:0] a);
      return (a == 4'd15) ? r15_in : m[a];
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 15; i++) m[i] <= '0;
         m_err <= 1'b0;
         m_cnt <= 0;
      end else if (we) begin
         if (idx_of(wsel) >= 0 && idx_of(wsel) < 15) begin
            m[idx_of(wsel)] <= wd;
            m_cnt <= (m_cnt >= 255) ? 255 : m_cnt + 1;
         end else if (idx_of(wsel) < 0) begin
            m_err <= 1'b1;
         end
      end
   end

   task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (chk_on) begin
         chk("rd1",      rd1,      exp_rd(ra1));
         chk("rd2",      rd2,      exp_rd(ra2));
         chk("dbg_out",  dbg_out,  exp_rd(rdbg));
         chk("sel_err",  {31'b0, sel_err}, {31'b0, m_err});
         chk("wr_count", {24'b0, wr_count}, m_cnt[W-1:0]);
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic rand_cycle(input bit legal_only, input int idx);
      int k;
      we     = legal_only ? 1'b1 : 1'($urandom_range(0, 1));
      wd     = $urandom;
      r15_in = $urandom;
      ra1    = 4'($urandom_range(0, 15));
      ra2    = 4'($urandom_range(0, 15));
      rdbg   = 4'($urandom_range(0, 15));
      if (legal_only) begin
         wsel = 16'h0001 << idx;
      end else begin
         k = $urandom_range(0, 9);
         if (k < 6)       wsel = 16'h0001 << $urandom_range(0, 15);
         else if (k == 6) wsel = 16'h0000;
         else             wsel = 16'($urandom) | 16'h0101;
      end
      step();
   endtask

   initial begin
      rst_n = 1'b0; we = 1'b0; wsel = '0; wd = '0;
      ra1 = '0; ra2 = '0; rdbg = '0; r15_in = 32'h0000_0108;
      step();
      for (int a = 0; a < 16; a++) begin
         ra1 = 4'(a);
         #1;
         chk("reset_rd1", rd1, (a == 15) ? 32'h0000_0108 : 32'h0);
      end
      chk("reset_sel_err", {31'b0, sel_err}, 32'h0);
      chk("reset_wr_count", {24'b0, wr_count}, 32'h0);
      #2 rst_n = 1'b1;
      chk_on = 1'b1;
      step();

      we = 1'b1; wsel = 16'h0020; wd = 32'hDEAD_BEEF; ra1 = 4'd5; ra2 = 4'd4;
      #1 chk("pre_edge_r5", rd1, 32'h0);
      step();
      we = 1'b0;
      chk("basic_r5", rd1, 32'hDEAD_BEEF);
      chk("basic_r4", rd2, 32'h0);
      chk("basic_count", {24'b0, wr_count}, 32'd1);

      we = 1'b1; wsel = 16'h0003; wd = 32'h1234_5678; ra1 = 4'd0; ra2 = 4'd1;
      step();
      chk("illegal_r0", rd1, 32'h0);
      chk("illegal_r1", rd2, 32'h0);
      chk("illegal_flag", {31'b0, sel_err}, 32'd1);
      chk("illegal_count", {24'b0, wr_count}, 32'd1);
      wsel = 16'h0004; wd = 32'h2222_2222; ra1 = 4'd2;
      step();
      chk("legal_after_err", rd1, 32'h2222_2222);
      chk("flag_sticky", {31'b0, sel_err}, 32'd1);
      chk("count_2", {24'b0, wr_count}, 32'd2);

      wsel = 16'h8000; wd = 32'hFFFF_FFFF; ra1 = 4'd15;
      step();
      chk("r15_read", rd1, 32'h0000_0108);
      chk("r15_count", {24'b0, wr_count}, 32'd2);
      we = 1'b0; wsel = 16'h0004; wd = 32'h0; ra1 = 4'd2;
      step();
      chk("we0_r2", rd1, 32'h2222_2222);
      wsel = 'x;
      step();
      wsel = '0;
      chk("we0_x_r2", rd1, 32'h2222_2222);
      chk("we0_x_count", {24'b0, wr_count}, 32'd2);

      we = 1'b1; wsel = 16'h0080; wd = 32'hA5A5_A5A5; ra1 = 4'd7;
      step();
      we = 1'b0;
      chk("r7_written", rd1, 32'hA5A5_A5A5);
      #2 rst_n = 1'b0;
      #1 chk("async_clear_r7", rd1, 32'h0);
      we = 1'b1; wsel = 16'h0080; wd = 32'h0000_0001;
      step();
      step();
      chk("reset_blocks_write", rd1, 32'h0);
      chk("reset_blocks_count", {24'b0, wr_count}, 32'h0);
      we = 1'b0;
      #2 rst_n = 1'b1;
      step();

      for (int i = 0; i < 300; i++) rand_cycle(1'b1, i % 15);
      we = 1'b0;
      chk("saturated", {24'b0, wr_count}, 32'h0000_00FF);
      chk("no_err_sat", {31'b0, sel_err}, 32'h0);

      for (int i = 0; i < 400; i++) rand_cycle(1'b0, 0);
      we = 1'b0;
      #2 rst_n = 1'b0;
      step();
      #2 rst_n = 1'b1;
      for (int i = 0; i < 300; i++) rand_cycle(1'b0, 0);
      we = 1'b0;
      step();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
